ext_mem_arbiter: RTL and testbench

//  Owns the shared external 16-bit async PSRAM bus. Arbitrates between the video frame fetch
//  (pixel-pair reads, strict priority) and a background loader (image/screen writes and reads

---
 rtl/ext_mem_arbiter_pkg.sv | 27 ++
 rtl/ext_mem_arbiter_mem_wait_cnt.sv | 44 ++++
 rtl/ext_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ext_mem_arbiter_pkg
//   Shared definitions for the external PSRAM arbiter. It holds the 2-bit FSM
//   state encodings, the bus-owner encoding, the default wait-state counts, and
//   a helper that sizes the wait counter so both the access and turnaround
//   reloads fit.
// ---------------------------------------------------------------------------
package ext_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_TURN_CYCLES   = 1;

  function automatic int cnt_width(input int access_cycles, input int turn_cycles);
    int m;
    m = (access_cycles > turn_cycles) ? access_cycles : turn_cycles;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_mem_wait_cnt.sv
// ---------------------------------------------------------------------------
// mem_wait_cnt
//   This is a loadable down-counter that times the strobe windows. It stops at
//   zero and never wraps. Every state entry reloads it.
// Ports
//   clk_i       clock
//   rst_n_i     synchronous active-low reset (count -> 0)
//   load_i      load load_val_i this cycle (has priority over decrement)
//   load_val_i  reload value
//   zero_o      count is zero
// ---------------------------------------------------------------------------
module mem_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ext_mem_arbiter
//   This module owns the shared 16-bit async PSRAM bus. Video pixel-pair reads
//   have strict priority over the background loader, which may only start an
//   access while ld_window is high. Every pin-side output comes from a
//   register. Video reads can run back-to-back, with one word every
//   ACCESS_CYCLES. A write is followed by a turnaround that holds the data
//   drivers for one cycle after WE rises.
// Ports
//   clk_40ns, rst_n                 clock, synchronous active-low reset
//   vid_req/vid_addr -> vid_gnt     video request handshake
//   vid_valid/vid_rdata             video read data, one-cycle valid pulse
//   vid_late                        sticky: video was held off by the loader
//   ld_window, ld_req, ld_we,
//   ld_addr, ld_wdata -> ld_gnt     loader request handshake
//   ld_done/ld_rdata                loader completion pulse, read data
//   mem_adr, mem_db_i/o, mem_db_oe,
//   ram_cs_n/oe_n/we_n              PSRAM pins
// ---------------------------------------------------------------------------
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 26,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES
) (
  input  logic              clk_40ns,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_late,
  input  logic              ld_window,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_db_i,
  output logic [DATA_W-1:0] mem_db_o,
  output logic              mem_db_oe,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int CNT_W = cnt_width(ACCESS_CYCLES, TURN_CYCLES);
  localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dbo_q, dbo_d;
  logic              dboe_q, dboe_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              vid_gnt_q, vid_gnt_d;
  logic              ld_gnt_q, ld_gnt_d;
  logic              vid_cap_q, vid_cap_d;
  logic              ld_cap_q, ld_cap_d;
  logic              vid_valid_q, vid_valid_d;
  logic              ld_done_q, ld_done_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              vid_late_q, vid_late_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              turn_done;

  mem_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk_i      (clk_40ns),
    .rst_n_i    (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    adr_d       = adr_q;
    dbo_d       = dbo_q;
    dboe_d      = dboe_q;
    cs_n_d      = cs_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    vid_gnt_d   = 1'b0;
    ld_gnt_d    = 1'b0;
    vid_cap_d   = 1'b0;
    ld_cap_d    = 1'b0;
    vid_rdata_d = vid_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    cnt_load    = 1'b0;
    cnt_val     = ACC_LOAD;
    turn_done   = 1'b0;

    // Video is "late" whenever it asks while the loader holds the bus.
    vid_late_d = vid_late_q |
                 (vid_req & ((state_q == ST_WR) || (state_q == ST_TURN) ||
                             ((state_q == ST_RD) && (owner_q == OWN_LD))));

    case (state_q)
      ST_IDLE: begin
        if (vid_req) begin
          vid_gnt_d = 1'b1;
          owner_d   = OWN_VID;
          adr_d     = vid_addr;
          cs_n_d    = 1'b0;
          oe_n_d    = 1'b0;
          cnt_load  = 1'b1;
          state_d   = ST_RD;
        end else if (ld_req && ld_window) begin
          ld_gnt_d = 1'b1;
          owner_d  = OWN_LD;
          adr_d    = ld_addr;
          cs_n_d   = 1'b0;
          cnt_load = 1'b1;
          if (ld_we) begin
            we_n_d  = 1'b0;
            dboe_d  = 1'b1;
            dbo_d   = ld_wdata;
            state_d = ST_WR;
          end else begin
            oe_n_d  = 1'b0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_zero) begin
          if (owner_q == OWN_VID) begin
            vid_rdata_d = mem_db_i;
            vid_cap_d   = 1'b1;
          end else begin
            ld_rdata_d = mem_db_i;
            ld_cap_d   = 1'b1;
          end
          // Only video chains reads. CS/OE stay low and the next address goes out on the capture edge.
          if ((owner_q == OWN_VID) && vid_req) begin
            vid_gnt_d = 1'b1;
            adr_d     = vid_addr;
            cnt_load  = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WR: begin
        if (cnt_zero) begin
          we_n_d   = 1'b1;
          cs_n_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = TURN_LOAD;
          state_d  = ST_TURN;
        end
      end
      ST_TURN: begin
        // Data stays driven for the first turnaround cycle (hold after WE rises), then it is released.
        dboe_d = 1'b0;
        if (cnt_zero) begin
          turn_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vid_valid_d = vid_cap_q;
    ld_done_d   = ld_cap_q | turn_done;
  end

  always_ff @(posedge clk_40ns) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VID;
      adr_q       <= '0;
      dbo_q       <= '0;
      dboe_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      vid_gnt_q   <= 1'b0;
      ld_gnt_q    <= 1'b0;
      vid_cap_q   <= 1'b0;
      ld_cap_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      ld_done_q   <= 1'b0;
      vid_rdata_q <= '0;
      ld_rdata_q  <= '0;
      vid_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      adr_q       <= adr_d;
      dbo_q       <= dbo_d;
      dboe_q      <= dboe_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      vid_gnt_q   <= vid_gnt_d;
      ld_gnt_q    <= ld_gnt_d;
      vid_cap_q   <= vid_cap_d;
      ld_cap_q    <= ld_cap_d;
      vid_valid_q <= vid_valid_d;
      ld_done_q   <= ld_done_d;
      vid_rdata_q <= vid_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      vid_late_q  <= vid_late_d;
    end
  end

  assign vid_gnt   = vid_gnt_q;
  assign vid_valid = vid_valid_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_late  = vid_late_q;
  assign ld_gnt    = ld_gnt_q;
  assign ld_done   = ld_done_q;
  assign ld_rdata  = ld_rdata_q;
  assign mem_adr   = adr_q;
  assign mem_db_o  = dbo_q;
  assign mem_db_oe = dboe_q;
  assign ram_cs_n  = cs_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_arbiter
//   This is a directed bench for ext_mem_arbiter with ACCESS_CYCLES=2 and
//   TURN_CYCLES=1. A small PSRAM model answers reads and records writes taken
//   from the pins. The stimulus pushes expected read words into per-requester
//   queues. A negedge monitor pops an entry and compares it on every vid_valid
//   or ld_done pulse.
// ---------------------------------------------------------------------------
module tb_ext_mem_arbiter;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;

  logic              clk_40ns = 1'b0;
  logic              rst_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_valid, vid_late;
  logic [DATA_W-1:0] vid_rdata;
  logic              ld_window, ld_req, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt, ld_done;
  logic [DATA_W-1:0] ld_rdata;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_db_i;
  logic [DATA_W-1:0] mem_db_o;
  logic              mem_db_oe, ram_cs_n, ram_oe_n, ram_we_n;

  ext_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(2), .TURN_CYCLES(1)
  ) dut (
    .clk_40ns(clk_40ns), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata), .vid_late(vid_late),
    .ld_window(ld_window), .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .mem_adr(mem_adr), .mem_db_i(mem_db_i), .mem_db_o(mem_db_o),
    .mem_db_oe(mem_db_oe), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  always #20 clk_40ns = ~clk_40ns;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int overlap = 0;

  always @(posedge clk_40ns) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- PSRAM model ----------------
  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h3C00;
  endfunction

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    if (a == 26'h25800) return 16'hE31C;
    for (int i = wa.size() - 1; i >= 0; i--) if (wa[i] == a) return wd[i];
    return dflt(a);
  endfunction

  initial mem_db_i = 16'hFFFF;
  always @(negedge clk_40ns)
    mem_db_i = (!ram_cs_n && !ram_oe_n) ? mem_read(mem_adr) : 16'hFFFF;

  always @(posedge clk_40ns)
    if (!ram_cs_n && !ram_we_n && mem_db_oe) begin
      wa.push_back(mem_adr);
      wd.push_back(mem_db_o);
    end

  // ---------------- scoreboard monitor ----------------
  logic [DATA_W-1:0] vid_q[$];
  logic [DATA_W-1:0] ld_q[$];

  always @(negedge clk_40ns) begin
    if (vid_valid) begin
      if (vid_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL vid_valid_unexpected: actual pulse rdata 0x%0h required no pulse (cycle %0d)", vid_rdata, cyc);
      end else check("vid_rdata", vid_rdata, vid_q.pop_front());
    end
    if (ld_done) begin
      if (ld_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ld_done_unexpected: actual pulse rdata 0x%0h required no pulse (cycle %0d)", ld_rdata, cyc);
      end else check("ld_rdata", ld_rdata, ld_q.pop_front());
    end
    if (!ram_oe_n && mem_db_oe) overlap++;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_vid_gnt(input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk_40ns);
      if (vid_gnt) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL vid_gnt_timeout: actual no grant required grant within %0d cycles", lim);
    end
  endtask

  task automatic wait_ld_gnt(input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk_40ns);
      if (ld_gnt) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL ld_gnt_timeout: actual no grant required grant within %0d cycles", lim);
    end
  endtask

  task automatic wait_ld_done(input int lim);
    int at;
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk_40ns);
      if (ld_done) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL ld_done_timeout: actual no done required done within %0d cycles", lim);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g, vg, lg, vcyc, dcyc, cnt_a, cnt_b;
    int addr, vcount, last_v, bad_sp, cs_hi, first_g, last_g, nogrant;

    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
    ld_window = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    repeat (2) @(posedge clk_40ns);
    @(negedge clk_40ns);
    check("rst_cs_n", ram_cs_n, 1);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_we_n", ram_we_n, 1);
    check("rst_db_oe", mem_db_oe, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_db_o", mem_db_o, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_vid_late", vid_late, 0);
    check("rst_gnts", {vid_gnt, ld_gnt, vid_valid, ld_done}, 0);
    rst_n = 1'b1;
    @(negedge clk_40ns);

    // Single video read
    vid_addr = 26'h25800; vid_req = 1'b1;
    vid_q.push_back(16'hE31C);
    wait_vid_gnt(10, g);
    check("rd1_mem_adr", mem_adr, 26'h25800);
    cnt_a = ram_oe_n ? 0 : 1;
    vid_req = 1'b0;
    vcyc = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_40ns);
      if (!ram_oe_n) cnt_a++;
      if (vid_valid) vcyc = cyc;
    end
    check("rd1_oe_low_cycles", cnt_a, 2);
    check("rd1_valid_latency", vcyc - g, 3);

    // Streaming 320 video words
    addr = 0; vid_addr = '0; vid_req = 1'b1;
    vcount = 0; last_v = -1; bad_sp = 0; cs_hi = 0; first_g = -1; last_g = -1;
    for (int k = 0; k < 1200 && vcount < 320; k++) begin
      @(negedge clk_40ns);
      if (vid_valid) begin
        if (last_v >= 0 && cyc - last_v != 2) bad_sp++;
        last_v = cyc; vcount++;
      end
      if (first_g >= 0 && (last_g < 0 || cyc <= last_g + 1) && ram_cs_n) cs_hi++;
      if (vid_gnt && vid_req) begin
        if (first_g < 0) first_g = cyc;
        vid_q.push_back(dflt(26'(addr)));
        addr++;
        if (addr == 320) begin vid_req = 1'b0; last_g = cyc; end
        else vid_addr = 26'(addr);
      end
    end
    check("stream_valid_count", vcount, 320);
    check("stream_spacing_errors", bad_sp, 0);
    check("stream_cs_high_cycles", cs_hi, 0);
    repeat (3) @(negedge clk_40ns);

    // Contention: video wins, loader after video drops
    vid_addr = 26'h100; vid_req = 1'b1;
    ld_window = 1'b1; ld_we = 1'b0; ld_addr = 26'h200; ld_req = 1'b1;
    vid_q.push_back(16'h3D00);
    ld_q.push_back(16'h3E00);
    vg = -1; lg = -1;
    for (int k = 0; k < 20 && lg < 0; k++) begin
      @(negedge clk_40ns);
      if (ld_gnt) begin lg = cyc; ld_req = 1'b0; end
      if (vid_gnt) begin vg = cyc; vid_req = 1'b0; end
    end
    check("cont_vid_granted", vg >= 0, 1);
    check("cont_ld_after_vid", lg - vg, 3);
    wait_ld_done(10);
    check("cont_vid_late", vid_late, 0);

    // Loader write 0xA5C3 @0x12C00, window dropped after grant
    ld_window = 1'b1; ld_we = 1'b1; ld_addr = 26'h12C00; ld_wdata = 16'hA5C3; ld_req = 1'b1;
    ld_q.push_back(16'h3E00);
    wait_ld_gnt(10, g);
    ld_req = 1'b0; ld_window = 1'b0;
    check("wr_mem_adr", mem_adr, 26'h12C00);
    check("wr_mem_db_o", mem_db_o, 16'hA5C3);
    cnt_a = ram_we_n ? 0 : 1;
    cnt_b = mem_db_oe ? 1 : 0;
    dcyc = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_40ns);
      if (!ram_we_n) cnt_a++;
      if (mem_db_oe) cnt_b++;
      if (ld_done && dcyc < 0) dcyc = cyc;
    end
    check("wr_we_low_cycles", cnt_a, 2);
    check("wr_db_oe_cycles", cnt_b, 3);
    check("wr_done_latency", dcyc - g, 3);
    check("wr_mem_content", mem_read(26'h12C00), 16'hA5C3);

    // Window closed: no loader grant
    ld_we = 1'b0; ld_req = 1'b1; nogrant = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_40ns);
      if (ld_gnt) nogrant++;
    end
    check("window_closed_no_gnt", nogrant, 0);

    // Read back
    ld_window = 1'b1;
    ld_q.push_back(16'hA5C3);
    wait_ld_gnt(10, g);
    ld_req = 1'b0;
    wait_ld_done(10);
    @(negedge clk_40ns);

    // Video arrives one cycle into a loader write
    ld_we = 1'b1; ld_addr = 26'h300; ld_wdata = 16'h1234; ld_req = 1'b1;
    ld_q.push_back(16'hA5C3);
    wait_ld_gnt(10, g);
    ld_req = 1'b0;
    @(negedge clk_40ns);
    vid_addr = 26'h5; vid_req = 1'b1;
    vid_q.push_back(16'h3C05);
    wait_vid_gnt(10, vg);
    vid_req = 1'b0;
    check("late_gnt_after_turn", vg - g, 4);
    check("late_set", vid_late, 1);
    repeat (6) @(negedge clk_40ns);
    check("late_sticky", vid_late, 1);

    // Reset during an active write
    ld_window = 1'b1; ld_we = 1'b1; ld_addr = 26'h400; ld_wdata = 16'hBEEF; ld_req = 1'b1;
    wait_ld_gnt(10, g);
    ld_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_40ns);
    check("rstw_we_n", ram_we_n, 1);
    check("rstw_cs_n", ram_cs_n, 1);
    check("rstw_db_oe", mem_db_oe, 0);
    @(negedge clk_40ns);
    rst_n = 1'b1;
    check("rstw_vid_late", vid_late, 0);
    check("rstw_ld_rdata", ld_rdata, 0);
    check("rstw_mem_adr", mem_adr, 0);
    repeat (8) @(negedge clk_40ns);

    check("vid_queue_drained", vid_q.size(), 0);
    check("ld_queue_drained", ld_q.size(), 0);
    check("oe_dboe_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL global_timeout: actual still running required finish");
    $fatal(1, "timeout");
  end

endmodule
